// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch controller: structure occupancy status and dispatch FSM state.
package dispatch_ctrl_pkg;

   typedef enum logic [1:0] {
      FULL      = 2'd0,
      ONE_LEFT  = 2'd1,
      MORE_LEFT = 2'd2
   } STRUCTURE_FULL;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } DISPATCH_STATE;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decode-buffer / occupancy / freelist signal bundle seen by the dispatch controller.
interface dispatch_ctrl_if
   import dispatch_ctrl_pkg::*;
#(
   parameter int unsigned BRANCH_BUFFER_SIZE = 4
);
   localparam int unsigned CNT_W = $clog2(BRANCH_BUFFER_SIZE + 1);

   logic [1:0]       inst_valid_i;
   logic [1:0]       inst_dest_i;
   logic [1:0]       inst_branch_i;
   STRUCTURE_FULL    freelist_status_i;
   STRUCTURE_FULL    rob_status_i;
   STRUCTURE_FULL    rs_status_i;
   logic [1:0]       retire_branch_i;
   logic [1:0]       branch_recover_i;
   logic [1:0]       dispatch_en_o;
   logic [1:0]       dispatch_branch_o;
   logic [1:0]       slot_take_o;
   logic             stall_o;
   logic             flush_o;
   logic [CNT_W-1:0] branch_count_o;
   logic [31:0]      stall_cycles_o;

   modport master (
      output inst_valid_i, inst_dest_i, inst_branch_i, freelist_status_i, rob_status_i,
             rs_status_i, retire_branch_i, branch_recover_i,
      input  dispatch_en_o, dispatch_branch_o, slot_take_o, stall_o, flush_o,
             branch_count_o, stall_cycles_o
   );

   modport slave (
      input  inst_valid_i, inst_dest_i, inst_branch_i, freelist_status_i, rob_status_i,
             rs_status_i, retire_branch_i, branch_recover_i,
      output dispatch_en_o, dispatch_branch_o, slot_take_o, stall_o, flush_o,
             branch_count_o, stall_cycles_o
   );

endinterface

// File: rtl/dispatch_ctrl_branch_credit_counter.sv
// In-flight branch counter: two increments, two decrements, clear; clamped to 0..SIZE.
module dispatch_ctrl_branch_credit_counter #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned CNT_W = $clog2(SIZE + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [1:0]       inc,
   input  logic [1:0]       dec,
   output logic [CNT_W-1:0] count
);
   localparam int unsigned W = CNT_W + 2;
   localparam logic [W-1:0] MAX = W'(SIZE);

   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     up, dn, diff;

   always_comb begin
      up      = W'(count_q) + W'(inc[0]) + W'(inc[1]);
      dn      = W'(dec[0]) + W'(dec[1]);
      diff    = '0;
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (dn > up) begin
         count_d = '0;
      end else begin
         diff    = up - dn;
         count_d = (diff > MAX) ? CNT_W'(MAX) : CNT_W'(diff);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// 2-wide in-order dispatch controller with branch credits and post-mispredict flush blackout.
module dispatch_ctrl
   import dispatch_ctrl_pkg::*;
#(
   parameter int unsigned BRANCH_BUFFER_SIZE = 4,
   parameter int unsigned FLUSH_CYCLES       = 2
) (
   input logic           clk,
   input logic           reset,
   dispatch_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(BRANCH_BUFFER_SIZE + 1);
   localparam logic [CNT_W:0] SIZE_W     = (CNT_W + 1)'(BRANCH_BUFFER_SIZE);
   localparam logic [2:0]     FLUSH_LOAD = 3'(FLUSH_CYCLES);

   DISPATCH_STATE    state_q, state_d;
   logic [2:0]       flush_cnt_q, flush_cnt_d;
   logic [31:0]      stall_cycles_q;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   count_w, br_sum;
   logic             recover_any, preg_ok, take0, take1;
   logic [1:0]       take;

   assign recover_any = |bus.branch_recover_i;
   assign count_w     = {1'b0, count};
   assign br_sum      = count_w + (CNT_W + 1)'(bus.inst_branch_i[0])
                                + (CNT_W + 1)'(bus.inst_branch_i[1]);

   always_comb begin
      unique case (bus.inst_dest_i)
         2'b11:        preg_ok = (bus.freelist_status_i == MORE_LEFT);
         2'b01, 2'b10: preg_ok = (bus.freelist_status_i != FULL);
         default:      preg_ok = 1'b1;
      endcase
   end

   assign take0 = bus.inst_valid_i[0] & (state_q == RUN) & ~recover_any
                & (bus.rob_status_i != FULL) & (bus.rs_status_i != FULL)
                & (~bus.inst_dest_i[0] | (bus.freelist_status_i != FULL))
                & (~bus.inst_branch_i[0] | (count_w < SIZE_W));

   // Slot 1 needs a second entry everywhere, so ONE_LEFT is not enough.
   assign take1 = take0 & bus.inst_valid_i[1]
                & (bus.rob_status_i == MORE_LEFT) & (bus.rs_status_i == MORE_LEFT)
                & preg_ok & (br_sum <= SIZE_W);

   assign take                  = {take1, take0};
   assign bus.slot_take_o       = take;
   assign bus.dispatch_en_o     = take & bus.inst_dest_i;
   assign bus.dispatch_branch_o = take & bus.inst_branch_i;
   assign bus.stall_o           = |(bus.inst_valid_i & ~take);
   assign bus.flush_o           = (state_q == RECOVER);
   assign bus.branch_count_o    = count;
   assign bus.stall_cycles_o    = stall_cycles_q;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      if (recover_any) begin
         state_d     = RECOVER;
         flush_cnt_d = FLUSH_LOAD;
      end else if (state_q == RECOVER) begin
         flush_cnt_d = flush_cnt_q - 3'd1;
         if (flush_cnt_q == 3'd1) state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         flush_cnt_q    <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         if (bus.stall_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
      end
   end

   dispatch_ctrl_branch_credit_counter #(
      .SIZE (BRANCH_BUFFER_SIZE),
      .CNT_W(CNT_W)
   ) u_branch_credit_counter (
      .clk  (clk),
      .reset(reset),
      .clear(recover_any),
      .inc  (bus.dispatch_branch_o),
      .dec  (bus.retire_branch_i),
      .count(count)
   );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: directed per-cycle vectors, negedge monitor compares.
module tb_dispatch_ctrl;
   import dispatch_ctrl_pkg::*;

   localparam int unsigned SIZE = 4;
   localparam int unsigned FLC  = 2;
   localparam int unsigned CW   = $clog2(SIZE + 1);
   localparam STRUCTURE_FULL M = MORE_LEFT;
   localparam STRUCTURE_FULL O = ONE_LEFT;
   localparam STRUCTURE_FULL F = FULL;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dispatch_ctrl_if #(.BRANCH_BUFFER_SIZE(SIZE)) bus ();

   dispatch_ctrl #(
      .BRANCH_BUFFER_SIZE(SIZE),
      .FLUSH_CYCLES      (FLC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      int              id;
      logic [1:0]      take;
      logic [1:0]      en;
      logic [1:0]      br;
      logic            stall;
      logic            flush;
      logic [CW-1:0]   cnt;
      logic [31:0]     sc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_x;
   int          n_cmp    = 0;
   int          n_fail   = 0;
   int          step_id  = 0;
   logic [31:0] model_sc = '0;

   function automatic void check(input string name, input int id,
                                 input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, want);
      end
   endfunction

   // Expected registered values are those visible during the cycle, before the edge.
   task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] d,
                       input logic [1:0] b, input STRUCTURE_FULL fl, input STRUCTURE_FULL rob,
                       input STRUCTURE_FULL rs, input logic [1:0] ret, input logic [1:0] rec,
                       input logic [1:0] t, input logic [1:0] e, input logic [1:0] bo,
                       input logic st, input logic fo, input logic [CW-1:0] cnt);
      exp_t x;
      @(posedge clk);
      #1;
      reset                 = rst;
      bus.inst_valid_i      = v;
      bus.inst_dest_i       = d;
      bus.inst_branch_i     = b;
      bus.freelist_status_i = fl;
      bus.rob_status_i      = rob;
      bus.rs_status_i       = rs;
      bus.retire_branch_i   = ret;
      bus.branch_recover_i  = rec;
      x.id = step_id; x.take = t; x.en = e; x.br = bo;
      x.stall = st; x.flush = fo; x.cnt = cnt; x.sc = model_sc;
      exp_q.push_back(x);
      if (rst)                                     model_sc = '0;
      else if (st && model_sc != 32'hFFFF_FFFF)    model_sc = model_sc + 32'd1;
      step_id++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_x = exp_q.pop_front();
         check("slot_take",       mon_x.id, 32'(bus.slot_take_o),       32'(mon_x.take));
         check("dispatch_en",     mon_x.id, 32'(bus.dispatch_en_o),     32'(mon_x.en));
         check("dispatch_branch", mon_x.id, 32'(bus.dispatch_branch_o), 32'(mon_x.br));
         check("stall",           mon_x.id, 32'(bus.stall_o),           32'(mon_x.stall));
         check("flush",           mon_x.id, 32'(bus.flush_o),           32'(mon_x.flush));
         check("branch_count",    mon_x.id, 32'(bus.branch_count_o),    32'(mon_x.cnt));
         check("stall_cycles",    mon_x.id, bus.stall_cycles_o,         mon_x.sc);
         check("count_in_range",  mon_x.id, 32'(bus.branch_count_o <= CW'(SIZE)), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      bus.inst_valid_i      = '0;
      bus.inst_dest_i       = '0;
      bus.inst_branch_i     = '0;
      bus.freelist_status_i = M;
      bus.rob_status_i      = M;
      bus.rs_status_i       = M;
      bus.retire_branch_i   = '0;
      bus.branch_recover_i  = '0;
      repeat (2) @(posedge clk);
      //   rst v     d     b     fl rob rs ret   rec   take  en    bo    st fo cnt
      step(0, 2'b00, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      step(0, 2'b11, 2'b11, 2'b00, M, M, M, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 0);
      step(0, 2'b11, 2'b11, 2'b00, O, M, M, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1, 0, 0);
      step(0, 2'b11, 2'b01, 2'b00, O, M, M, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, O, M, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0);
      step(0, 2'b11, 2'b01, 2'b00, F, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      // Branch credits: fill to SIZE, block, retire one, resume.
      step(0, 2'b11, 2'b00, 2'b11, M, M, M, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 0);
      step(0, 2'b01, 2'b00, 2'b01, M, M, M, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 2);
      step(0, 2'b11, 2'b00, 2'b11, M, M, M, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 1, 0, 3);
      step(0, 2'b01, 2'b00, 2'b01, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 4);
      step(0, 2'b01, 2'b00, 2'b01, M, M, M, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 4);
      step(0, 2'b01, 2'b00, 2'b01, M, M, M, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 3);
      step(0, 2'b00, 2'b00, 2'b00, M, M, M, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 4);
      // Recover with count=2, then blackout of FLC cycles.
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 2);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      step(0, 2'b11, 2'b11, 2'b00, M, M, M, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 0);
      // Second recover inside RECOVER extends the blackout.
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0);
      // Reset in the middle of RECOVER.
      step(0, 2'b11, 2'b00, 2'b11, M, M, M, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 0);
      step(0, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 2);
      step(1, 2'b11, 2'b00, 2'b00, M, M, M, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      step(0, 2'b11, 2'b11, 2'b00, M, M, M, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 0);
      repeat (2) @(posedge clk);
      check("scoreboard_drained", step_id, 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

2-wide in-order dispatch controller between the decode buffer and the rename/allocate stage. Each cycle it decides how many of the two decoded instructions may dispatch, based on freelist, ROB and RS occupancy status and on branch-buffer credits. It generates the per-slot preg requests to the freelist and blocks dispatch during a fixed-length flush window after a branch mispredict.

## Interface
Parameters:
- BRANCH_BUFFER_SIZE, 4: maximum in-flight branches; must match the freelist branch-head buffer.
- FLUSH_CYCLES, 2: length of the post-recovery dispatch blackout, 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_valid_i  in  [1:0]  decoded instruction valid per slot
- inst_dest_i  in  [1:0]  slot writes an architectural destination and needs a preg
- inst_branch_i  in  [1:0]  slot is a branch
- freelist_status_i  in  STRUCTURE_FULL  freelist FULL/ONE_LEFT/MORE_LEFT
- rob_status_i  in  STRUCTURE_FULL  ROB availability
- rs_status_i  in  STRUCTURE_FULL  RS availability
- retire_branch_i  in  [1:0]  retiring instruction in the slot is a branch
- branch_recover_i  in  [1:0]  mispredict recovery, slot 0 or slot 1
- dispatch_en_o  out  [1:0]  preg request to freelist (slot taken AND dest)
- dispatch_branch_o  out  [1:0]  slot taken AND branch, to freelist/branch buffer
- slot_take_o  out  [1:0]  instruction consumed from decode buffer
- stall_o  out  1  some valid slot not taken
- flush_o  out  1  recovery blackout active
- branch_count_o  out  $clog2(BRANCH_BUFFER_SIZE+1)  in-flight branches
- stall_cycles_o  out  32  saturating count of cycles with stall_o=1

## Operation
- State machine with two states: RUN and RECOVER; down-counter flush_cnt is 3 bits wide.
- take0 = valid0 & RUN & ~recover_any & rob≠FULL & rs≠FULL & (~dest0 | fl≠FULL) & (~br0 | count<SIZE).
- take1 = take0 & valid1 & rob==MORE_LEFT & rs==MORE_LEFT & preg rule & branch rule.
  - Preg rule: need = dest0+dest1. need=2 requires fl==MORE_LEFT; need=1 requires fl≠FULL.
  - Branch rule: count+br0+br1 ≤ SIZE.
- Slot 1 never dispatches without slot 0; dispatch is strictly in order.
- dispatch_en_o = take & dest; dispatch_branch_o = take & branch; slot_take_o = take.
- stall_o = |(inst_valid_i & ~slot_take_o). stall_o is asserted during RECOVER whenever any slot is valid.
- recover_any = |branch_recover_i.
- Branch count:
  - With no recover: count_next = count + popcount(dispatch_branch_o) − popcount(retire_branch_i).
  - The free check uses the registered count only; retiring credits are not bypassed.
  - Underflow must not occur. The bench asserts this; RTL clamps at 0.
- On recover_any: count_next=0; state→RECOVER; flush_cnt=FLUSH_CYCLES. This takes priority over dispatch and retire in the same cycle.
- In RECOVER: flush_o=1, no takes, flush_cnt decrements each cycle. When flush_cnt==1, state→RUN at the next edge.
- A recover_any arriving during RECOVER reloads flush_cnt to FLUSH_CYCLES.
- stall_cycles_o increments when stall_o=1 and saturates at 32'hFFFF_FFFF.

## Timing
- All take/enable outputs are combinational from the current inputs and registered state, in the same cycle.
- Recover seen in cycle t:
  - Dispatch is suppressed in t.
  - flush_o=1 in t+1 .. t+FLUSH_CYCLES.
  - First possible dispatch is t+FLUSH_CYCLES+1.
- branch_count_o, flush_o and stall_cycles_o are registered outputs.
- Reset values:
  - State RUN, flush_cnt=0, branch_count_o=0, flush_o=0, stall_cycles_o=0.
  - Combinational outputs follow inputs with RUN state; with inst_valid_i=0 they are all 0.
- Reset mid-RECOVER returns to RUN on the next cycle and clears all counters.

## Structure
- STRUCTURE_FULL is reused from the shared sys_defs package.
- A new DISPATCH_STATE enum {RUN, RECOVER} is added to the same package.
- One natural sub-module, branch_credit_counter:
  - Holds count with up to 2 inc / 2 dec / clear inputs.
  - Clamps to the range 0..SIZE and outputs count.
- Everything else is inline: take logic, FSM, stall counter.

## Test plan
- Both slots valid, dest=11, fl/rob/rs=MORE_LEFT, count=0 → take=11, dispatch_en=11, stall_o=0.
- dest=11, fl=ONE_LEFT → take=01, dispatch_en=01, stall_o=1. Same with dest=01 → take=11, dispatch_en=01.
- SIZE=4, count=3, br=11 → take=01, count→4. Next cycle br0=1 → take=00 until a retire_branch_i=01 drops count to 3, then take resumes.
- count=2, branch_recover_i=01 at cycle t with valid=11 → take=00 in t; flush_o=1 in t+1,t+2; count=0; take=11 in t+3.
- Second recover at t+1 during RECOVER → flush_o extends through t+3; dispatch resumes at t+4.
- 5 stall cycles, then reset mid-RECOVER → stall_cycles_o=0, flush_o=0, count=0 next cycle.
